// File: rtl/dvma_req_arbiter.sv
// -----------------------------------------------------------------------------
// dvma_req_arbiter
//
// Sits in front of the DVMA controller and owns its two request inputs:
// /rreq (DRAM refresh) and /xreq (external DMA). A free-running interval
// timer produces refresh ticks that build up a small backlog (pend). Two DMA
// requesters share the single /xreq slot under round-robin arbitration. Each
// cycle is followed through the controller's /p.back handshake, and a
// watchdog aborts cycles that stay outstanding too long. A full backlog
// takes priority over DMA.
//
// Parameters
//   REFRESH_PERIOD  clocks between refresh ticks (4..4095)
//   TIMEOUT         maximum clocks a cycle may stay outstanding (8..4095)
//
// Ports
//   CLK        in   board clock, all state on the rising edge
//   RESET_n    in   asynchronous active-low reset
//   req_n      in   DMA requests, active-low (bit 0 Multibus, bit 1 DVMA master)
//   back_n     in   /p.back, low while the controller owns the bus for us
//   gnt_n      out  one-hot-low grant to the requester owning /xreq
//   xreq_n     out  /xreq to the DVMA controller
//   rreq_n     out  /rreq to the DVMA controller
//   timeout_n  out  one-clock low pulse when the watchdog expires
//   ovr_n      out  sticky low once the refresh backlog overflowed
//   pend       out  refresh backlog count (debug)
// -----------------------------------------------------------------------------
module dvma_req_arbiter #(
  parameter int REFRESH_PERIOD = 250,
  parameter int TIMEOUT        = 255
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic [1:0] req_n,
  input  logic       back_n,
  output logic [1:0] gnt_n,
  output logic       xreq_n,
  output logic       rreq_n,
  output logic       timeout_n,
  output logic       ovr_n,
  output logic [1:0] pend
);

  localparam int CW = 12;
  localparam logic [CW-1:0] TMR_RELOAD = CW'(REFRESH_PERIOD - 1);
  // Watchdog value on the edge that is the TIMEOUT-th clock of a cycle; the
  // entry edge itself counts as clock 1.
  localparam logic [CW-1:0] WD_LAST    = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RREQ,
    S_RBUSY,
    S_XREQ,
    S_XBUSY
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   tmr_q, tmr_d;
  logic [CW-1:0]   wd_q, wd_d;
  logic            ptr_q, ptr_d;     // requester favoured when both ask
  logic            sel_q, sel_d;     // requester currently owning /xreq
  logic [1:0]      pend_q, pend_d;
  logic            ovr_n_q, ovr_n_d;
  logic [1:0]      gnt_n_q, gnt_n_d;
  logic            xreq_n_q, xreq_n_d;
  logic            rreq_n_q, rreq_n_d;
  logic            timeout_n_q, timeout_n_d;

  logic            tick;
  logic            wd_hit;
  logic            expire;
  logic            rfsh_done;

  // ---------------------------------------------------------------------------
  // Refresh interval timer: free-running, independent of arbitration.
  // ---------------------------------------------------------------------------
  assign tick  = (tmr_q == '0);
  assign tmr_d = tick ? TMR_RELOAD : tmr_q - CW'(1);

  // ---------------------------------------------------------------------------
  // Sequencer next-state logic.
  // ---------------------------------------------------------------------------
  assign wd_hit = (wd_q == WD_LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    wd_d      = wd_q;
    expire    = 1'b0;
    rfsh_done = 1'b0;

    if (state_q == S_IDLE) begin
      // The watchdog restarts on leaving IDLE and then spans the whole
      // cycle (request and busy phases), so the entry edge is preloaded as 1.
      wd_d = CW'(1);
      if (pend_q == 2'd3) begin
        state_d = S_RREQ;
      end else if (req_n != 2'b11) begin
        state_d = S_XREQ;
        // Both asking: the pointer decides. One asking: req_n[0] is 0 exactly
        // when requester 0 is the one asking.
        sel_d   = (req_n == 2'b00) ? ptr_q : req_n[0];
      end else if (pend_q != 2'd0) begin
        state_d = S_RREQ;
      end
    end else begin
      wd_d = wd_q + CW'(1);
      if (wd_hit) begin
        // Aborted cycles complete like normal ones: a refresh is consumed,
        // a DMA grant hands the pointer to the other requester.
        expire  = 1'b1;
        state_d = S_IDLE;
        if (state_q == S_RREQ || state_q == S_RBUSY) begin
          rfsh_done = 1'b1;
        end else begin
          ptr_d = ~sel_q;
        end
      end else begin
        unique case (state_q)
          S_RREQ: begin
            if (!back_n) state_d = S_RBUSY;
          end
          S_RBUSY: begin
            if (back_n) begin
              rfsh_done = 1'b1;
              state_d   = S_IDLE;
            end
          end
          S_XREQ: begin
            // Bus ownership wins over a withdrawal seen on the same edge.
            if (!back_n) begin
              state_d = S_XBUSY;
            end else if (req_n[sel_q]) begin
              state_d = S_IDLE;      // withdrawal: pointer stays put
            end
          end
          S_XBUSY: begin
            if (back_n) begin
              ptr_d   = ~sel_q;
              state_d = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh backlog: a tick and a completion on the same edge cancel out.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d  = pend_q;
    ovr_n_d = ovr_n_q;
    unique case ({tick, rfsh_done})
      2'b10: begin
        if (pend_q == 2'd3) ovr_n_d = 1'b0;
        else                pend_d  = pend_q + 2'd1;
      end
      2'b01: begin
        if (pend_q != 2'd0) pend_d = pend_q - 2'd1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state; the results are registered, so no
  // combinational path exists from req_n/back_n to any output. Deriving
  // gnt_n from the same next state as xreq_n keeps them consistent.
  // ---------------------------------------------------------------------------
  always_comb begin
    rreq_n_d    = !(state_d == S_RREQ || state_d == S_RBUSY);
    xreq_n_d    = !(state_d == S_XREQ || state_d == S_XBUSY);
    gnt_n_d     = xreq_n_d ? 2'b11 : (sel_d ? 2'b01 : 2'b10);
    timeout_n_d = !expire;
  end

  // ---------------------------------------------------------------------------
  // State registers. The asynchronous reset releases both requests
  // immediately, even in the middle of a bus cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!RESET_n) begin
      state_q     <= S_IDLE;
      tmr_q       <= TMR_RELOAD;
      wd_q        <= '0;
      ptr_q       <= 1'b0;
      sel_q       <= 1'b0;
      pend_q      <= 2'd0;
      ovr_n_q     <= 1'b1;
      gnt_n_q     <= 2'b11;
      xreq_n_q    <= 1'b1;
      rreq_n_q    <= 1'b1;
      timeout_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      wd_q        <= wd_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      pend_q      <= pend_d;
      ovr_n_q     <= ovr_n_d;
      gnt_n_q     <= gnt_n_d;
      xreq_n_q    <= xreq_n_d;
      rreq_n_q    <= rreq_n_d;
      timeout_n_q <= timeout_n_d;
    end
  end

  assign gnt_n     = gnt_n_q;
  assign xreq_n    = xreq_n_q;
  assign rreq_n    = rreq_n_q;
  assign timeout_n = timeout_n_q;
  assign ovr_n     = ovr_n_q;
  assign pend      = pend_q;

endmodule

// File: tb/tb_dvma_req_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for dvma_req_arbiter. The bench plays the DVMA controller (drives
// back_n) and both DMA requesters. A behavioural model, kept in terms of
// "who owns the bus, since which clock, how many refreshes are owed", predicts
// every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_dvma_req_arbiter;

  localparam int P = 8;    // REFRESH_PERIOD
  localparam int T = 30;   // TIMEOUT

  logic       CLK;
  logic       RESET_n;
  logic [1:0] req_n;
  logic       back_n;
  logic [1:0] gnt_n;
  logic       xreq_n;
  logic       rreq_n;
  logic       timeout_n;
  logic       ovr_n;
  logic [1:0] pend;

  dvma_req_arbiter #(
    .REFRESH_PERIOD(P),
    .TIMEOUT       (T)
  ) dut (
    .CLK      (CLK),
    .RESET_n  (RESET_n),
    .req_n    (req_n),
    .back_n   (back_n),
    .gnt_n    (gnt_n),
    .xreq_n   (xreq_n),
    .rreq_n   (rreq_n),
    .timeout_n(timeout_n),
    .ovr_n    (ovr_n),
    .pend     (pend)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: owner 0 = nobody, 1 = refresh, 2 = DMA requester m_who.
  int m_clk;      // edges since reset release
  int m_owner;
  int m_who;
  int m_busy;     // controller has answered with back_n low
  int m_start;    // edge on which the current cycle was granted
  int m_ptr;
  int m_pend;
  int m_ovr;
  int m_to;

  // Controller responder: after a grant waits r_wait clocks, then holds
  // back_n low for r_hold clocks, then releases it.
  int r_active, r_wait, r_hold;
  int rmode;      // 0 = fixed wait/hold, 1 = random per cycle
  int fix_wait, fix_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_clk = 0; m_owner = 0; m_who = 0; m_busy = 0; m_start = 0;
    m_ptr = 0; m_pend = 0; m_ovr = 0; m_to = 0; r_active = 0;
  endtask

  task automatic model_edge(input logic [1:0] r, input logic b);
    int tick, done;
    m_clk++;
    tick = ((m_clk % P) == 0) ? 1 : 0;
    done = 0;
    m_to = 0;
    if (m_owner == 0) begin
      if (m_pend == 3) m_owner = 1;
      else if (r != 2'b11) begin
        m_owner = 2;
        if (r == 2'b00) m_who = m_ptr;
        else            m_who = (r[0] == 1'b0) ? 0 : 1;
      end else if (m_pend > 0) m_owner = 1;
      if (m_owner != 0) begin
        m_start = m_clk;
        m_busy  = 0;
      end
    end else if (m_clk - m_start + 1 == T) begin
      m_to = 1;
      if (m_owner == 1) done = 1; else m_ptr = 1 - m_who;
      m_owner = 0;
    end else if (m_busy == 0) begin
      if (!b) m_busy = 1;
      else if (m_owner == 2 && r[m_who]) m_owner = 0;
    end else if (b) begin
      if (m_owner == 1) done = 1; else m_ptr = 1 - m_who;
      m_owner = 0;
    end
    if (tick == 1 && done == 0) begin
      if (m_pend == 3) m_ovr = 1; else m_pend++;
    end else if (tick == 0 && done == 1) begin
      m_pend--;
    end
  endtask

  task automatic compare_all();
    logic [1:0] eg;
    eg = (m_owner == 2) ? ((m_who == 0) ? 2'b10 : 2'b01) : 2'b11;
    check("gnt_n", 32'(gnt_n), 32'(eg));
    check("xreq_n", 32'(xreq_n), (m_owner == 2) ? 0 : 1);
    check("rreq_n", 32'(rreq_n), (m_owner == 1) ? 0 : 1);
    check("timeout_n", 32'(timeout_n), (m_to != 0) ? 0 : 1);
    check("ovr_n", 32'(ovr_n), (m_ovr != 0) ? 0 : 1);
    check("pend", 32'(pend), m_pend);
  endtask

  task automatic respond(output logic b);
    int pick;
    b = 1'b1;
    if (m_owner == 0) begin
      r_active = 0;
    end else begin
      if (r_active == 0) begin
        r_active = 1;
        if (rmode == 0) begin
          r_wait = fix_wait; r_hold = fix_hold;
        end else begin
          pick = $urandom_range(0, 9);
          if (pick == 0)      begin r_wait = 100; r_hold = 0;   end
          else if (pick == 1) begin r_wait = 0;   r_hold = 100; end
          else begin
            r_wait = $urandom_range(0, 3);
            r_hold = $urandom_range(0, 4);
          end
        end
      end
      if (r_wait > 0)      begin r_wait--; b = 1'b1; end
      else if (r_hold > 0) begin r_hold--; b = 1'b0; end
    end
  endtask

  // Drive inputs at the falling edge, advance the model on the rising edge,
  // compare at the next falling edge.
  task automatic step(input logic [1:0] r, input logic b);
    req_n  = r;
    back_n = b;
    @(posedge CLK);
    model_edge(r, b);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_gnt_n"}, 32'(gnt_n), 32'h3);
    check({pfx, "_xreq_n"}, 32'(xreq_n), 1);
    check({pfx, "_rreq_n"}, 32'(rreq_n), 1);
    check({pfx, "_timeout_n"}, 32'(timeout_n), 1);
    check({pfx, "_ovr_n"}, 32'(ovr_n), 1);
    check({pfx, "_pend"}, 32'(pend), 0);
  endtask

  initial begin
    logic b;
    int first, cnt, reached;

    RESET_n = 1'b0;
    req_n   = 2'b11;
    back_n  = 1'b1;
    rmode   = 0; fix_wait = 0; fix_hold = 2;
    model_reset();
    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    RESET_n = 1'b1;

    // Refresh only, back_n low 2 clocks per cycle.
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      respond(b);
      step(2'b11, b);
      if (first == 0 && rreq_n === 1'b0) first = i;
    end
    check("first_rreq_clock", first, P + 1);

    // Both requesters continuously, back_n low 3 clocks per grant.
    fix_wait = 0; fix_hold = 3;
    for (int i = 0; i < 60; i++) begin
      respond(b);
      step(2'b00, b);
    end

    // Backlog: controller never answers, so cycles end by watchdog while
    // refresh ticks pile up.
    fix_wait = 1000; fix_hold = 0;
    for (int i = 0; i < 120; i++) begin
      respond(b);
      step(2'b00, b);
    end
    check("ovr_sticky", 32'(ovr_n), 0);

    // Randomized requests and controller behaviour.
    rmode = 1;
    for (int i = 0; i < 800; i++) begin
      respond(b);
      step(2'($urandom_range(0, 3)), b);
    end

    // Fresh start, then reach RBUSY with two refreshes owed.
    RESET_n = 1'b0;
    #1;
    model_reset();
    @(negedge CLK);
    RESET_n = 1'b1;
    rmode = 0; fix_wait = P + 2; fix_hold = 100;
    reached = 0;
    for (int i = 0; i < 200 && reached == 0; i++) begin
      respond(b);
      step(2'b11, b);
      if (m_owner == 1 && m_busy == 1 && m_pend == 2) reached = 1;
    end
    check("rbusy_pend", 32'(pend), 2);
    check("rbusy_rreq_n", 32'(rreq_n), 0);

    // Asynchronous reset mid-cycle: outputs must drop with no clock edge.
    #2;
    RESET_n = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    @(negedge CLK);
    RESET_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3 * P; i++) begin
      respond(b);
      step(2'b11, b);
      cnt++;
      if (pend !== 2'd0) break;
    end
    check("first_tick_after_reset", cnt, P);
    for (int i = 0; i < 20; i++) begin
      respond(b);
      step(2'b11, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
